calc_seq: RTL and testbench



---
 rtl/calc_seq.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_calc_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// calc_seq: serial-display calculator with NDIG-digit decimal operands.
// Commands arrive over a cmd_valid handshake that is honoured only while
// status reports ready. Add/sub/mul (and optionally div) run for exactly W
// cycles, then the result is scanned out one BCD digit per cycle.
// Optional feature: define CALC_DIV_EN to enable the divide operator (cmd 1101)
// and build the restoring divider; without it, 1101 traps to the error state.
// The reset input is asynchronous and active-low; its release is synchronised
// internally, so the block accepts commands two clocks after release.
module calc_seq #(
    parameter int NDIG = 8,
    parameter int W    = 27,
    parameter int PW   = $clog2(NDIG + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [3:0]    cmd,
    output logic [1:0]    status,
    output logic [3:0]    data,
    output logic [PW-1:0] pos,
    output logic [W-1:0]  digits
);

    localparam longint          MAXV_L    = (longint'(10) ** NDIG) - 1;
    localparam logic [W-1:0]    MAXV      = W'(MAXV_L);
    localparam int              XW        = W + 4;
    localparam int              CW        = $clog2(W);
    localparam logic [PW-1:0]   POS_IDLE  = '1;
    localparam logic [PW-1:0]   SCAN_LAST = PW'(NDIG - 1);
    localparam logic [CW-1:0]   CALC_LAST = CW'(W - 1);

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    // Operator encoding is simply the low two bits of the operator command.
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam logic [3:0] CMD_DIV = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BS  = 4'd15;

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_ENTRY_B,
        ST_CALC,
        ST_SCAN,
        ST_ERROR
    } state_t;

    logic [1:0]     rst_sync_q, rst_sync_d;
    logic           rst_n_int;

    state_t         state_q, state_d;
    logic           ret_b_q, ret_b_d;
    logic [W-1:0]   digits_q, digits_d;
    logic [W-1:0]   rega_q, rega_d;
    logic [W-1:0]   regb_q, regb_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   scan_q, scan_d;
    logic [PW-1:0]  scan_cnt_q, scan_cnt_d;
    logic           err_hold_q, err_hold_d;
    logic [CW-1:0]  calc_cnt_q, calc_cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mca_q, mca_d;
    logic [W-1:0]   mpl_q, mpl_d;
`ifdef CALC_DIV_EN
    localparam logic [1:0] OP_DIV = 2'b01;
    logic           divz_q, divz_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W:0]     rem_shift;
    logic [W-1:0]   rem_step, quo_step;
`endif

    logic           in_entry, accept;
    logic           is_digit, is_op, is_eq, is_bs, op_ok;
    logic [XW-1:0]  digit_ext;
    logic [W-1:0]   digit_val, bs_val, scan_div10;
    logic [W:0]     sum_ext;
    logic [2*W-1:0] acc_step;
    logic [W-1:0]   calc_res;
    logic           calc_err, calc_last, scan_last;

    // Command decode; only entry states present ready, so only they accept.
    assign in_entry  = (state_q == ST_ENTRY_A) || (state_q == ST_ENTRY_B);
    assign accept    = cmd_valid && in_entry;
    assign is_digit  = (cmd < 4'd10);
    assign is_op     = (cmd >= 4'd10) && (cmd <= CMD_DIV);
    assign is_eq     = (cmd == CMD_EQ);
    assign is_bs     = (cmd == CMD_BS);
`ifdef CALC_DIV_EN
    assign op_ok     = is_op;
`else
    assign op_ok     = is_op && (cmd != CMD_DIV);
`endif

    // Digit append saturates by refusing the digit rather than clipping.
    assign digit_ext  = {4'b0000, digits_q} * XW'(10) + XW'(cmd);
    assign digit_val  = (digit_ext <= XW'(MAXV)) ? digit_ext[W-1:0] : digits_q;
    assign bs_val     = digits_q / W'(10);
    assign scan_div10 = scan_q / W'(10);
    assign sum_ext    = {1'b0, rega_q} + {1'b0, regb_q};
    assign acc_step   = mpl_q[0] ? (acc_q + mca_q) : acc_q;
    assign calc_last  = (calc_cnt_q == CALC_LAST);
    assign scan_last  = (scan_cnt_q == SCAN_LAST);

    // One iteration of each datapath plus the final result/overflow check.
    always_comb begin
        calc_res = '0;
        calc_err = 1'b0;
`ifdef CALC_DIV_EN
        rem_shift = {rem_q, quo_q[W-1]};
        if (rem_shift >= {1'b0, regb_q}) begin
            rem_step = W'(rem_shift - {1'b0, regb_q});
            quo_step = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[W-1:0];
            quo_step = {quo_q[W-2:0], 1'b0};
        end
`endif
        case (op_q)
            OP_ADD: begin
                calc_res = sum_ext[W-1:0];
                calc_err = (sum_ext > {1'b0, MAXV});
            end
            OP_SUB: begin
                calc_res = rega_q - regb_q;
                calc_err = (regb_q > rega_q);
            end
            OP_MUL: begin
                calc_res = acc_step[W-1:0];
                calc_err = (acc_step > {{W{1'b0}}, MAXV});
            end
            default: begin
`ifdef CALC_DIV_EN
                if (op_q == OP_DIV) begin
                    calc_res = quo_step;
                    calc_err = divz_q;
                end
`else
                calc_err = 1'b1;
`endif
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTRY_A: if (accept) begin
                if (is_digit || is_bs) state_d = ST_SCAN;
                else if (is_op)        state_d = op_ok ? ST_SCAN : ST_ERROR;
            end
            ST_ENTRY_B: if (accept) begin
                if (is_digit || is_bs) state_d = ST_SCAN;
                else if (is_op)        state_d = ST_ERROR;
                else if (is_eq)        state_d = ST_CALC;
            end
            ST_CALC:  if (calc_last) state_d = calc_err ? ST_ERROR : ST_SCAN;
            ST_SCAN:  if (scan_last) state_d = ret_b_q ? ST_ENTRY_B : ST_ENTRY_A;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ENTRY_A;
        endcase
    end

    // Datapath updates: entry edits, operand capture, iteration and scan shift.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        ret_b_d    = ret_b_q;
        digits_d   = digits_q;
        rega_d     = rega_q;
        regb_d     = regb_q;
        op_d       = op_q;
        scan_d     = scan_q;
        scan_cnt_d = scan_cnt_q;
        err_hold_d = err_hold_q;
        calc_cnt_d = calc_cnt_q;
        acc_d      = acc_q;
        mca_d      = mca_q;
        mpl_d      = mpl_q;
`ifdef CALC_DIV_EN
        divz_d     = divz_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
`endif
        case (state_q)
            ST_ENTRY_A, ST_ENTRY_B: if (accept) begin
                scan_cnt_d = '0;
                if (is_digit) begin
                    digits_d = digit_val;
                    scan_d   = digit_val;
                end else if (is_bs) begin
                    digits_d = bs_val;
                    scan_d   = bs_val;
                end else if (is_op) begin
                    // Both a valid first operator and an error clear the display.
                    digits_d   = '0;
                    scan_d     = '0;
                    err_hold_d = 1'b0;
                    if ((state_q == ST_ENTRY_A) && op_ok) begin
                        rega_d  = digits_q;
                        op_d    = cmd[1:0];
                        ret_b_d = 1'b1;
                    end
                end else if (is_eq && (state_q == ST_ENTRY_B)) begin
                    regb_d     = digits_q;
                    calc_cnt_d = '0;
                    acc_d      = '0;
                    mca_d      = {{W{1'b0}}, rega_q};
                    mpl_d      = digits_q;
`ifdef CALC_DIV_EN
                    divz_d     = (digits_q == '0);
                    rem_d      = '0;
                    quo_d      = rega_q;
`endif
                end
            end
            ST_CALC: begin
                calc_cnt_d = calc_cnt_q + 1'b1;
                acc_d      = acc_step;
                mca_d      = {mca_q[2*W-2:0], 1'b0};
                mpl_d      = {1'b0, mpl_q[W-1:1]};
`ifdef CALC_DIV_EN
                rem_d      = rem_step;
                quo_d      = quo_step;
`endif
                if (calc_last) begin
                    scan_cnt_d = '0;
                    ret_b_d    = 1'b0;
                    err_hold_d = 1'b0;
                    digits_d   = calc_err ? '0 : calc_res;
                    scan_d     = calc_err ? '0 : calc_res;
                end
            end
            ST_SCAN: begin
                scan_d     = scan_div10;
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
            ST_ERROR: if (!err_hold_q) begin
                scan_d     = scan_div10;
                scan_cnt_d = scan_cnt_q + 1'b1;
                if (scan_last) err_hold_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output decode straight from state so reset takes effect immediately.
    always_comb begin
        status = ST_READY;
        pos    = POS_IDLE;
        data   = 4'd0;
        case (state_q)
            ST_CALC: status = ST_BUSY;
            ST_SCAN: begin
                status = ST_BUSY;
                pos    = scan_cnt_q;
                data   = 4'(scan_q % W'(10));
            end
            ST_ERROR: begin
                status = ST_ERR;
                if (!err_hold_q) begin
                    pos  = scan_cnt_q;
                    data = 4'(scan_q % W'(10));
                end
            end
            default: ;
        endcase
    end

    assign digits    = digits_q;
    assign rst_n_int = rst_sync_q[1];

    // Reset release synchroniser: asserts asynchronously, releases after two clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    // State register.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) state_q <= ST_ENTRY_A;
        else            state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ret_b_q    <= 1'b0;
            digits_q   <= '0;
            rega_q     <= '0;
            regb_q     <= '0;
            op_q       <= '0;
            scan_q     <= '0;
            scan_cnt_q <= '0;
            err_hold_q <= 1'b0;
            calc_cnt_q <= '0;
            acc_q      <= '0;
            mca_q      <= '0;
            mpl_q      <= '0;
`ifdef CALC_DIV_EN
            divz_q     <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
`endif
        end else begin
            ret_b_q    <= ret_b_d;
            digits_q   <= digits_d;
            rega_q     <= rega_d;
            regb_q     <= regb_d;
            op_q       <= op_d;
            scan_q     <= scan_d;
            scan_cnt_q <= scan_cnt_d;
            err_hold_q <= err_hold_d;
            calc_cnt_q <= calc_cnt_d;
            acc_q      <= acc_d;
            mca_q      <= mca_d;
            mpl_q      <= mpl_d;
`ifdef CALC_DIV_EN
            divz_q     <= divz_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
`endif
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq (NDIG=8, W=27): entry, backspace, overflow
// refusal, add/sub/mul/div, error trapping, dropped commands and async reset.
`timescale 1ns/1ps
module tb_calc_seq;

    localparam int NDIG = 8;
    localparam int W    = 27;
    localparam int PW   = 4;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [3:0]    cmd       = 4'd0;
    logic [1:0]    status;
    logic [3:0]    data;
    logic [PW-1:0] pos;
    logic [W-1:0]  digits;

    int nvec = 0;
    int nerr = 0;

    calc_seq #(.NDIG(NDIG), .W(W), .PW(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .status    (status),
        .data      (data),
        .pos       (pos),
        .digits    (digits)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [3:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd       = 4'd0;
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] st);
        chk({tag, " status"}, 64'(status), 64'(st));
        chk({tag, " pos"},    64'(pos),    64'hF);
        chk({tag, " data"},   64'(data),   64'd0);
    endtask

    task automatic chk_scan(input string tag, input logic [63:0] val, input logic [1:0] st);
        logic [63:0] v;
        v = val;
        for (int i = 0; i < NDIG; i++) begin
            chk($sformatf("%s scan%0d status", tag, i), 64'(status), 64'(st));
            chk($sformatf("%s scan%0d pos", tag, i),    64'(pos),    64'(i));
            chk($sformatf("%s scan%0d data", tag, i),   64'(data),   v % 10);
            v = v / 10;
            step();
        end
    endtask

    task automatic entry(input string tag, input logic [3:0] c, input logic [63:0] val);
        send(c);
        chk({tag, " digits"}, 64'(digits), val);
        chk_scan(tag, val, 2'b01);
        chk_idle({tag, " done"}, 2'b10);
    endtask

    task automatic equals(input string tag, input logic [63:0] val, input logic err);
        send(4'hE);
        for (int i = 0; i < W; i++) begin
            chk($sformatf("%s calc%0d", tag, i), 64'({status, pos}), 64'({2'b01, 4'hF}));
            step();
        end
        chk({tag, " digits"}, 64'(digits), err ? 64'd0 : val);
        chk_scan(tag, err ? 64'd0 : val, err ? 2'b00 : 2'b01);
        chk_idle({tag, " done"}, err ? 2'b00 : 2'b10);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [63:0] v;

        // Power-on reset values while reset is held
        #3 reset = 1'b0;
        #1;
        chk_idle("reset", 2'b10);
        chk("reset digits", 64'(digits), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Digit entry and backspace
        entry("d1", 4'd1, 64'd1);
        entry("d2", 4'd2, 64'd12);
        entry("d3", 4'd3, 64'd123);
        entry("bs", 4'd15, 64'd12);

        // Nine nines: the ninth digit is refused
        do_reset();
        v = 0;
        for (int k = 0; k < 8; k++) begin
            v = v * 10 + 9;
            entry($sformatf("nine%0d", k), 4'd9, v);
        end
        entry("nine9th", 4'd9, 64'd99999999);

        // 25 + 17 = 42, then 42 * 3 = 126
        do_reset();
        entry("a2", 4'd2, 64'd2);
        entry("a5", 4'd5, 64'd25);
        entry("addop", 4'd10, 64'd0);
        entry("b1", 4'd1, 64'd1);
        entry("b7", 4'd7, 64'd17);
        equals("add", 64'd42, 1'b0);
        entry("mulop", 4'd12, 64'd0);
        entry("m3", 4'd3, 64'd3);
        equals("mul", 64'd126, 1'b0);

        // 5 - 7 underflows into the error trap
        do_reset();
        entry("s5", 4'd5, 64'd5);
        entry("subop", 4'd11, 64'd0);
        entry("s7", 4'd7, 64'd7);
        equals("sub", 64'd0, 1'b1);
        send(4'd1);
        chk_idle("errhold", 2'b00);
        chk("errhold digits", 64'(digits), 64'd0);
        repeat (4) step();
        chk("errhold late", 64'(status), 64'd0);
        do_reset();
        chk_idle("after err reset", 2'b10);
        chk("after err digits", 64'(digits), 64'd0);

`ifdef CALC_DIV_EN
        // 100 / 7 = 14, then divide by zero traps
        do_reset();
        entry("q1", 4'd1, 64'd1);
        entry("q10", 4'd0, 64'd10);
        entry("q100", 4'd0, 64'd100);
        entry("divop", 4'd13, 64'd0);
        entry("q7", 4'd7, 64'd7);
        equals("div", 64'd14, 1'b0);
        do_reset();
        entry("z4", 4'd4, 64'd4);
        entry("zdivop", 4'd13, 64'd0);
        entry("z0", 4'd0, 64'd0);
        equals("div0", 64'd0, 1'b1);
`else
        // Divide operator is not available: immediate error with zero scan
        do_reset();
        entry("q1", 4'd1, 64'd1);
        entry("q10", 4'd0, 64'd10);
        entry("q100", 4'd0, 64'd100);
        send(4'd13);
        chk("divoff digits", 64'(digits), 64'd0);
        chk_scan("divoff", 64'd0, 2'b00);
        chk_idle("divoff hold", 2'b00);
`endif

        // Command pulsed during a scan is dropped
        do_reset();
        send(4'd5);
        chk("pulse pre digits", 64'(digits), 64'd5);
        step();
        step();
        cmd       = 4'd7;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd       = 4'd0;
        chk("pulse digits", 64'(digits), 64'd5);
        chk("pulse pos", 64'(pos), 64'd3);
        chk("pulse status", 64'(status), 64'd1);
        repeat (5) step();
        chk_idle("pulse done", 2'b10);
        chk("pulse final digits", 64'(digits), 64'd5);

        // Reset in the middle of 99999999 * 2
        do_reset();
        v = 0;
        for (int k = 0; k < 8; k++) begin
            v = v * 10 + 9;
            entry($sformatf("big%0d", k), 4'd9, v);
        end
        entry("bigmul", 4'd12, 64'd0);
        entry("big2", 4'd2, 64'd2);
        send(4'hE);
        repeat (10) step();
        chk("midcalc busy", 64'(status), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk_idle("midcalc reset", 2'b10);
        chk("midcalc digits", 64'(digits), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
